// File: rtl/acquisition_sequencer.sv
// rtl/acquisition_sequencer.sv - flush / pre-fill / arm / post-capture / drain sequencer for a 4-channel sample FIFO bank
//
// Purpose: runs one acquisition through four FIFOs that share one write enable
// and one read enable. It flushes the datapath, keeps a pre-trigger window,
// waits for a trigger edge, captures the post-trigger window, and then drains
// the FIFOs as one 16-bit valid/ready stream ordered ch0..ch3 per sample.
//
// Ports:
//   i_Clock, i_Reset          clock, synchronous active-high reset
//   i_Start, i_Abort          one-cycle control pulses
//   i_Pre/Post_Trig_Samples   window lengths, latched on an accepted start
//   i_Trigger_In              trigger level; its rising edge is the trigger
//   o_Fifo_WE, o_Fifo_RE      shared FIFO write / read enables
//   o_Reset_N_Fifo/Trigger    active-low datapath resets, low during flush
//   i_Q_0..i_Q_3              FIFO read data
//   o_Out_Data/Valid/Last     output stream, i_Out_Ready is its back-pressure
//   o_Busy, o_Done, o_Cfg_Error, o_State   status

module acquisition_sequencer #(
    parameter int g_Fifo_Depth   = 1024,
    parameter int g_Count_Width  = 11,
    parameter int g_Read_Latency = 1,
    parameter int g_Flush_Cycles = 4
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     i_Start,
    input  logic                     i_Abort,
    input  logic [g_Count_Width-1:0] i_Pre_Trig_Samples,
    input  logic [g_Count_Width-1:0] i_Post_Trig_Samples,
    input  logic                     i_Trigger_In,
    output logic                     o_Fifo_WE,
    output logic                     o_Fifo_RE,
    output logic                     o_Reset_N_Fifo,
    output logic                     o_Reset_N_Trigger,
    input  logic [15:0]              i_Q_0,
    input  logic [15:0]              i_Q_1,
    input  logic [15:0]              i_Q_2,
    input  logic [15:0]              i_Q_3,
    output logic [15:0]              o_Out_Data,
    output logic                     o_Out_Valid,
    input  logic                     i_Out_Ready,
    output logic                     o_Out_Last,
    output logic                     o_Busy,
    output logic                     o_Done,
    output logic                     o_Cfg_Error,
    output logic [2:0]               o_State
);

    localparam int CW = g_Count_Width;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FLUSH    = 3'd1;
    localparam logic [2:0] S_PRE_FILL = 3'd2;
    localparam logic [2:0] S_ARMED    = 3'd3;
    localparam logic [2:0] S_POST     = 3'd4;
    localparam logic [2:0] S_RD_REQ   = 3'd5;
    localparam logic [2:0] S_RD_WAIT  = 3'd6;
    localparam logic [2:0] S_SEND     = 3'd7;

    localparam logic [CW-1:0] lp_one        = CW'(1);
    localparam logic [CW-1:0] lp_flush_last = CW'(g_Flush_Cycles - 1);
    localparam logic [CW-1:0] lp_wait_last  = CW'(g_Read_Latency - 1);
    localparam logic [CW:0]   lp_depth      = (CW+1)'(g_Fifo_Depth);

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_pre;
    logic [CW-1:0] r_post;
    logic [CW-1:0] r_samp;
    logic [1:0]    r_ch;
    logic          r_aborted;
    logic          r_trig_d;
    logic          r_done;
    logic          r_cfg_error;
    logic [15:0]   r_hold [0:3];

    logic [2:0]    w_next;
    logic [CW:0]   w_sum;
    logic          w_cfg_ok;
    logic          w_start_ok;
    logic          w_trig_edge;
    logic          w_abort;
    logic [CW-1:0] w_n;
    logic [CW-1:0] w_post_rem;
    logic          w_last_sample;
    logic          w_accept;
    logic          w_restart;

    // One extra bit so an oversized pair of windows cannot wrap to a legal sum.
    assign w_sum       = {1'b0, i_Pre_Trig_Samples} + {1'b0, i_Post_Trig_Samples};
    assign w_cfg_ok    = (w_sum != '0) && (w_sum <= lp_depth);
    assign w_start_ok  = (r_state == S_IDLE) && i_Start && w_cfg_ok;
    assign w_trig_edge = i_Trigger_In & ~r_trig_d;
    assign w_abort     = i_Abort && (r_state != S_IDLE);
    assign w_n         = r_pre + r_post;
    // With a pre-trigger window the trigger-cycle sample already counts as
    // the first post-trigger sample, so POST writes one fewer.
    assign w_post_rem    = ((r_pre != '0) && (r_post != '0)) ? (r_post - lp_one) : r_post;
    assign w_last_sample = (r_samp == (w_n - lp_one));
    assign w_accept      = (r_state == S_SEND) && i_Out_Ready && !w_abort;
    // An abort inside FLUSH restarts the flush, so it also clears the counter.
    assign w_restart     = (w_next != r_state) || w_abort;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_FLUSH;
        end else begin
            case (r_state)
                S_IDLE:     if (w_start_ok) w_next = S_FLUSH;
                S_FLUSH: begin
                    if (r_cnt == lp_flush_last) begin
                        if (r_aborted)          w_next = S_IDLE;
                        else if (r_pre == '0)   w_next = S_ARMED;
                        else                    w_next = S_PRE_FILL;
                    end
                end
                S_PRE_FILL: if (r_cnt == (r_pre - lp_one)) w_next = S_ARMED;
                S_ARMED: begin
                    if (w_trig_edge) w_next = (w_post_rem == '0) ? S_RD_REQ : S_POST;
                end
                S_POST:     if (r_cnt == (w_post_rem - lp_one)) w_next = S_RD_REQ;
                S_RD_REQ:   w_next = S_RD_WAIT;
                S_RD_WAIT:  if (r_cnt == lp_wait_last) w_next = S_SEND;
                S_SEND: begin
                    if (w_accept && (r_ch == 2'd3)) w_next = w_last_sample ? S_IDLE : S_RD_REQ;
                end
                default:    w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_cnt       <= '0;
            r_pre       <= '0;
            r_post      <= '0;
            r_samp      <= '0;
            r_ch        <= 2'd0;
            r_aborted   <= 1'b0;
            r_trig_d    <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_error <= 1'b0;
            for (int i = 0; i < 4; i++) r_hold[i] <= 16'd0;
        end else begin
            r_trig_d    <= i_Trigger_In;
            r_cfg_error <= (r_state == S_IDLE) && i_Start && !w_cfg_ok;
            r_done      <= w_accept && (r_ch == 2'd3) && w_last_sample;

            if (w_restart) begin
                r_cnt <= '0;
            end else if ((r_state == S_FLUSH) || (r_state == S_PRE_FILL) ||
                         (r_state == S_POST)  || (r_state == S_RD_WAIT)) begin
                r_cnt <= r_cnt + lp_one;
            end

            if (w_start_ok) begin
                r_pre  <= i_Pre_Trig_Samples;
                r_post <= i_Post_Trig_Samples;
            end

            if (w_abort) begin
                r_aborted <= 1'b1;
            end else if ((r_state == S_FLUSH) && (w_next != S_FLUSH)) begin
                r_aborted <= 1'b0;
            end

            if (r_state == S_RD_REQ) begin
                r_ch <= 2'd0;
            end else if (w_accept) begin
                r_ch <= r_ch + 2'd1;
            end

            if (w_start_ok) begin
                r_samp <= '0;
            end else if (w_accept && (r_ch == 2'd3)) begin
                r_samp <= r_samp + lp_one;
            end

            // Q_x is valid in the last RD_WAIT cycle; hold it for the whole SEND.
            if ((r_state == S_RD_WAIT) && (r_cnt == lp_wait_last)) begin
                r_hold[0] <= i_Q_0;
                r_hold[1] <= i_Q_1;
                r_hold[2] <= i_Q_2;
                r_hold[3] <= i_Q_3;
            end
        end
    end

    always_comb begin
        o_Fifo_WE   = 1'b0;
        o_Fifo_RE   = 1'b0;
        o_Out_Valid = 1'b0;
        o_Out_Last  = 1'b0;
        o_Out_Data  = 16'd0;
        case (r_state)
            S_PRE_FILL: o_Fifo_WE = 1'b1;
            S_ARMED: begin
                // Write+read keeps the FIFO at exactly Pre samples. On the
                // trigger cycle the read stops so the trigger sample is kept,
                // unless there is no post window at all.
                if (r_pre != '0) begin
                    o_Fifo_WE = !w_trig_edge || (r_post != '0);
                    o_Fifo_RE = !w_trig_edge;
                end
            end
            S_POST:     o_Fifo_WE = 1'b1;
            S_RD_REQ:   o_Fifo_RE = 1'b1;
            S_SEND: begin
                o_Out_Valid = 1'b1;
                o_Out_Last  = (r_ch == 2'd3) && w_last_sample;
                o_Out_Data  = r_hold[r_ch];
            end
            default: ;
        endcase
        if (w_abort) begin
            o_Fifo_WE   = 1'b0;
            o_Fifo_RE   = 1'b0;
            o_Out_Valid = 1'b0;
            o_Out_Last  = 1'b0;
        end
    end

    assign o_Reset_N_Fifo    = (r_state != S_FLUSH);
    assign o_Reset_N_Trigger = (r_state != S_FLUSH);
    assign o_Busy            = (r_state != S_IDLE);
    assign o_Done            = r_done;
    assign o_Cfg_Error       = r_cfg_error;
    assign o_State           = r_state;

endmodule

// File: tb/tb_acquisition_sequencer.sv
// tb/tb_acquisition_sequencer.sv - directed self-checking bench for acquisition_sequencer

module tb_acquisition_sequencer;

    logic        clk;
    logic        i_Reset, i_Start, i_Abort, i_Trigger_In, i_Out_Ready;
    logic [10:0] i_Pre, i_Post;
    logic        o_Fifo_WE, o_Fifo_RE, o_Reset_N_Fifo, o_Reset_N_Trigger;
    logic [15:0] q0, q1, q2, q3, o_Out_Data;
    logic        o_Out_Valid, o_Out_Last, o_Busy, o_Done, o_Cfg_Error;
    logic [2:0]  o_State;

    int n_checks = 0;
    int n_errors = 0;
    int rdy_mode = 0;

    acquisition_sequencer dut (
        .i_Clock(clk), .i_Reset(i_Reset), .i_Start(i_Start), .i_Abort(i_Abort),
        .i_Pre_Trig_Samples(i_Pre), .i_Post_Trig_Samples(i_Post),
        .i_Trigger_In(i_Trigger_In), .o_Fifo_WE(o_Fifo_WE), .o_Fifo_RE(o_Fifo_RE),
        .o_Reset_N_Fifo(o_Reset_N_Fifo), .o_Reset_N_Trigger(o_Reset_N_Trigger),
        .i_Q_0(q0), .i_Q_1(q1), .i_Q_2(q2), .i_Q_3(q3),
        .o_Out_Data(o_Out_Data), .o_Out_Valid(o_Out_Valid), .i_Out_Ready(i_Out_Ready),
        .o_Out_Last(o_Out_Last), .o_Busy(o_Busy), .o_Done(o_Done),
        .o_Cfg_Error(o_Cfg_Error), .o_State(o_State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO bank model: sample index s appears on channel k as {s[13:0], k}.
    logic [15:0] fifo_q [$];
    logic [15:0] wr_idx = 16'd0;
    logic [15:0] q_s = 16'd0;
    assign q0 = {q_s[13:0], 2'd0};
    assign q1 = {q_s[13:0], 2'd1};
    assign q2 = {q_s[13:0], 2'd2};
    assign q3 = {q_s[13:0], 2'd3};

    initial begin
        logic c_we, c_re, c_rst;
        forever begin
            @(negedge clk);
            c_we  = o_Fifo_WE;
            c_re  = o_Fifo_RE;
            c_rst = !o_Reset_N_Fifo;
            @(posedge clk);
            #1;
            if (c_rst) begin
                fifo_q.delete();
                wr_idx = 16'd0;
            end else begin
                if (c_re && (fifo_q.size() > 0)) q_s = fifo_q.pop_front();
                if (c_we) begin
                    fifo_q.push_back(wr_idx);
                    wr_idx = wr_idx + 16'd1;
                end
            end
        end
    end

    // Running totals observed on the DUT outputs.
    int we_tot = 0, we_armed = 0, re_pend = 0, done_tot = 0, cfg_tot = 0;
    int busy_tot = 0, rstf_tot = 0, rstt_tot = 0, valid_tot = 0, hold_viol = 0;
    int word_cnt = 0;
    logic [15:0] words [0:255];
    logic        lasts [0:255];

    initial begin
        logic        p_valid, p_ready;
        logic [15:0] p_data;
        p_valid = 1'b0;
        p_ready = 1'b0;
        p_data  = 16'd0;
        forever begin
            @(negedge clk);
            if (o_Fifo_WE) we_tot++;
            if (o_Fifo_WE && (o_State == 3'd3)) we_armed++;
            if (o_Fifo_RE && o_Out_Valid) re_pend++;
            if (o_Done) done_tot++;
            if (o_Cfg_Error) cfg_tot++;
            if (o_Busy) busy_tot++;
            if (!o_Reset_N_Fifo) rstf_tot++;
            if (!o_Reset_N_Trigger) rstt_tot++;
            if (o_Out_Valid) valid_tot++;
            if (p_valid && !p_ready && (!o_Out_Valid || (o_Out_Data != p_data))) hold_viol++;
            if (o_Out_Valid && i_Out_Ready && (word_cnt < 256)) begin
                words[word_cnt] = o_Out_Data;
                lasts[word_cnt] = o_Out_Last;
                word_cnt++;
            end
            p_valid = o_Out_Valid;
            p_ready = i_Out_Ready;
            p_data  = o_Out_Data;
        end
    end

    initial begin
        i_Out_Ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rdy_mode == 1) i_Out_Ready = ($urandom_range(0, 9) < 3);
            else               i_Out_Ready = 1'b1;
        end
    end

    int b_we, b_wa, b_re, b_done, b_cfg, b_busy, b_rstf, b_rstt, b_valid, b_hold, b_words;

    task automatic snap();
        b_we = we_tot; b_wa = we_armed; b_re = re_pend; b_done = done_tot;
        b_cfg = cfg_tot; b_busy = busy_tot; b_rstf = rstf_tot; b_rstt = rstt_tot;
        b_valid = valid_tot; b_hold = hold_viol; b_words = word_cnt;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n;
        n = 0;
        while ((o_State != s) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check_val("reach_state", 32'(o_State), 32'(s));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (o_Busy && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check_val("reach_idle", 32'(o_Busy), 32'd0);
    endtask

    task automatic start_pulse();
        drive_edge();
        i_Start = 1'b1;
        drive_edge();
        i_Start = 1'b0;
    endtask

    // Expected stream: samples first_s.. in order, ch0..ch3, last flag on word n-1.
    task automatic check_words(input string tag, input int n, input int first_s);
        logic [15:0] e;
        logic        el;
        check_val({tag, "_count"}, 32'(word_cnt - b_words), 32'(n));
        for (int i = 0; i < n; i++) begin
            e  = 16'(((first_s + i / 4) << 2) | (i % 4));
            el = (i == n - 1);
            check_val({tag, "_word"}, {15'd0, lasts[b_words + i], words[b_words + i]}, {15'd0, el, e});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        i_Reset = 1'b1; i_Start = 1'b0; i_Abort = 1'b0; i_Trigger_In = 1'b0;
        i_Pre = 11'd0; i_Post = 11'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_state", 32'(o_State), 32'd0);
        check_val("rst_we", 32'(o_Fifo_WE), 32'd0);
        check_val("rst_re", 32'(o_Fifo_RE), 32'd0);
        check_val("rst_rstn_fifo", 32'(o_Reset_N_Fifo), 32'd1);
        check_val("rst_rstn_trig", 32'(o_Reset_N_Trigger), 32'd1);
        check_val("rst_valid", 32'(o_Out_Valid), 32'd0);
        check_val("rst_last", 32'(o_Out_Last), 32'd0);
        check_val("rst_data", 32'(o_Out_Data), 32'd0);
        check_val("rst_busy", 32'(o_Busy), 32'd0);
        check_val("rst_done", 32'(o_Done), 32'd0);
        check_val("rst_cfgerr", 32'(o_Cfg_Error), 32'd0);
        drive_edge();
        i_Reset = 1'b0;
        drive_edge();

        // Pre=4, Post=4, trigger on the 21st ARMED cycle: keeps samples 20..27.
        snap();
        i_Pre = 11'd4; i_Post = 11'd4;
        start_pulse();
        wait_state(3'd3, 50);
        repeat (20) drive_edge();
        i_Trigger_In = 1'b1;
        drive_edge(); drive_edge();
        i_Trigger_In = 1'b0;
        wait_idle(1000);
        repeat (3) drive_edge();
        check_val("a_we_total", 32'(we_tot - b_we), 32'd28);
        check_val("a_we_armed", 32'(we_armed - b_wa), 32'd21);
        check_val("a_done", 32'(done_tot - b_done), 32'd1);
        check_val("a_flush_fifo", 32'(rstf_tot - b_rstf), 32'd4);
        check_val("a_flush_trig", 32'(rstt_tot - b_rstt), 32'd4);
        check_words("a", 32, 20);

        // Pre=0, Post=3: nothing written until the trigger, then samples 0..2.
        snap();
        i_Pre = 11'd0; i_Post = 11'd3;
        start_pulse();
        wait_state(3'd3, 50);
        repeat (5) drive_edge();
        i_Trigger_In = 1'b1;
        drive_edge(); drive_edge();
        i_Trigger_In = 1'b0;
        wait_idle(500);
        repeat (3) drive_edge();
        check_val("b_we_total", 32'(we_tot - b_we), 32'd3);
        check_val("b_we_armed", 32'(we_armed - b_wa), 32'd0);
        check_val("b_done", 32'(done_tot - b_done), 32'd1);
        check_words("b", 12, 0);

        // Rejected configurations, then the largest legal sum is accepted.
        snap();
        i_Pre = 11'd1000; i_Post = 11'd100;
        start_pulse();
        @(negedge clk);
        check_val("c_cfgerr_pulse", 32'(o_Cfg_Error), 32'd1);
        check_val("c_state_idle", 32'(o_State), 32'd0);
        i_Pre = 11'd0; i_Post = 11'd0;
        start_pulse();
        @(negedge clk);
        check_val("c_zero_cfgerr", 32'(o_Cfg_Error), 32'd1);
        repeat (3) drive_edge();
        check_val("c_cfg_count", 32'(cfg_tot - b_cfg), 32'd2);
        check_val("c_busy", 32'(busy_tot - b_busy), 32'd0);
        check_val("c_no_reset", 32'(rstf_tot - b_rstf), 32'd0);
        i_Pre = 11'd1020; i_Post = 11'd4;
        start_pulse();
        @(negedge clk);
        check_val("c_full_accept", 32'(o_State), 32'd1);
        check_val("c_full_no_err", 32'(o_Cfg_Error), 32'd0);
        drive_edge();
        i_Abort = 1'b1;
        drive_edge();
        i_Abort = 1'b0;
        wait_idle(50);

        // Pre=2, Post=2 with 30% ready: samples 3..6, stalls must hold data.
        snap();
        rdy_mode = 1;
        i_Pre = 11'd2; i_Post = 11'd2;
        start_pulse();
        wait_state(3'd3, 50);
        repeat (3) drive_edge();
        i_Trigger_In = 1'b1;
        drive_edge(); drive_edge();
        i_Trigger_In = 1'b0;
        wait_idle(3000);
        rdy_mode = 0;
        repeat (3) drive_edge();
        check_val("d_we_total", 32'(we_tot - b_we), 32'd7);
        check_val("d_re_pending", 32'(re_pend - b_re), 32'd0);
        check_val("d_hold", 32'(hold_viol - b_hold), 32'd0);
        check_val("d_done", 32'(done_tot - b_done), 32'd1);
        check_words("d", 16, 3);

        // Abort in POST: enables drop at once, 4 flush cycles, then IDLE.
        i_Pre = 11'd2; i_Post = 11'd8;
        start_pulse();
        wait_state(3'd3, 50);
        drive_edge();
        i_Trigger_In = 1'b1;
        drive_edge();
        i_Trigger_In = 1'b0;
        wait_state(3'd4, 5);
        drive_edge();
        snap();
        i_Abort = 1'b1;
        @(negedge clk);
        check_val("e_we_abort", 32'(o_Fifo_WE), 32'd0);
        check_val("e_state_post", 32'(o_State), 32'd4);
        check_val("e_rstn_abort", 32'(o_Reset_N_Fifo), 32'd1);
        drive_edge();
        i_Abort = 1'b0;
        wait_idle(50);
        repeat (5) drive_edge();
        check_val("e_flush_fifo", 32'(rstf_tot - b_rstf), 32'd4);
        check_val("e_flush_trig", 32'(rstt_tot - b_rstt), 32'd4);
        check_val("e_busy_cycles", 32'(busy_tot - b_busy), 32'd5);
        check_val("e_no_we", 32'(we_tot - b_we), 32'd0);
        check_val("e_no_done", 32'(done_tot - b_done), 32'd0);
        check_val("e_no_valid", 32'(valid_tot - b_valid), 32'd0);
        check_val("e_state_idle", 32'(o_State), 32'd0);

        // Trigger held high from IDLE: only a fresh edge in ARMED counts;
        // a Start while busy must not relatch the windows.
        snap();
        i_Trigger_In = 1'b1;
        i_Pre = 11'd3; i_Post = 11'd2;
        start_pulse();
        wait_state(3'd3, 50);
        repeat (4) drive_edge();
        i_Pre = 11'd5; i_Post = 11'd5; i_Start = 1'b1;
        drive_edge();
        i_Start = 1'b0;
        repeat (5) drive_edge();
        @(negedge clk);
        check_val("f_still_armed", 32'(o_State), 32'd3);
        drive_edge();
        i_Trigger_In = 1'b0;
        drive_edge();
        i_Trigger_In = 1'b1;
        drive_edge(); drive_edge();
        i_Trigger_In = 1'b0;
        wait_idle(1000);
        repeat (3) drive_edge();
        check_val("f_we_total", 32'(we_tot - b_we), 32'd17);
        check_val("f_cfg", 32'(cfg_tot - b_cfg), 32'd0);
        check_val("f_done", 32'(done_tot - b_done), 32'd1);
        check_words("f", 20, 12);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
